ov7670_pixel_packer: RTL

//  Camera capture front end, sitting between the OV7670 data pins and the camera-to-LCD ASYNC_FIFO write port.

---
 rtl/ov7670_pixel_packer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ov7670_pixel_packer.sv
// OV7670 capture front end: registers sensor pins, pairs bytes into RGB565,
// optionally 2:1 decimates in both axes and writes kept pixels to a FIFO.
module ov7670_pixel_packer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter bit DECIMATE    = 1'b1,
    parameter bit HI_BYTE_1ST = 1'b1
) (
    input  logic        c_PCLK,
    input  logic        rst,
    input  logic        c_VSYNC,
    input  logic        c_HREF,
    input  logic [7:0]  c_DOUT,
    input  logic        fifo_full,
    output logic [15:0] w_data,
    output logic        w_en,
    output logic        frame_start,
    output logic        frame_done,
    output logic [16:0] pix_count,
    output logic        overflow
);

    typedef enum logic [1:0] {SYNC, VBLANK, CAPTURE} state_t;

    localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

    state_t      state, state_nxt;
    logic        vs_q, vs_d, href_q, href_d;
    logic [7:0]  dout_q, first_byte;
    logic        phase;
    logic [11:0] col, row;
    logic        pend;
    logic [15:0] pend_word, word;
    logic [16:0] run_count;
    logic        start_evt, done_evt, capturing;
    logic        vs_rise, vs_fall, href_rise, href_fall;
    logic        pix_formed, keep;

    assign vs_rise   = vs_q & ~vs_d;
    assign vs_fall   = ~vs_q & vs_d;
    assign href_rise = href_q & ~href_d;
    assign href_fall = ~href_q & href_d;

    always_comb begin
        state_nxt = state;
        start_evt = 1'b0;
        done_evt  = 1'b0;
        case (state)
            SYNC:    if (vs_rise) state_nxt = VBLANK;
            VBLANK:  if (vs_fall) begin
                         state_nxt = CAPTURE;
                         start_evt = 1'b1;
                     end
            CAPTURE: if (vs_rise) begin
                         state_nxt = VBLANK;
                         done_evt  = 1'b1;
                     end
            default: state_nxt = SYNC;
        endcase
    end

    // A vsync rise in CAPTURE wins over any pixel activity in the same cycle.
    assign capturing  = (state == CAPTURE) && !done_evt;
    assign pix_formed = capturing && href_q && !href_rise && phase;
    assign keep       = (col < H_LIM) && (row < V_LIM) &&
                        (!DECIMATE || (!col[0] && !row[0]));
    assign word       = HI_BYTE_1ST ? {first_byte, dout_q} : {dout_q, first_byte};

    always_ff @(posedge c_PCLK or posedge rst) begin
        if (rst) begin
            state       <= SYNC;
            vs_q        <= 1'b0;
            vs_d        <= 1'b0;
            href_q      <= 1'b0;
            href_d      <= 1'b0;
            dout_q      <= '0;
            first_byte  <= '0;
            phase       <= 1'b0;
            col         <= '0;
            row         <= '0;
            pend        <= 1'b0;
            pend_word   <= '0;
            run_count   <= '0;
            w_data      <= '0;
            w_en        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            pix_count   <= '0;
            overflow    <= 1'b0;
        end else begin
            vs_q        <= c_VSYNC;
            vs_d        <= vs_q;
            href_q      <= c_HREF;
            href_d      <= href_q;
            dout_q      <= c_DOUT;
            state       <= state_nxt;
            frame_start <= start_evt;
            frame_done  <= done_evt;
            w_en        <= 1'b0;

            if (start_evt) begin
                col       <= '0;
                row       <= '0;
                phase     <= 1'b0;
                run_count <= '0;
            end
            if (done_evt)
                pix_count <= run_count;

            if (capturing) begin
                if (href_rise) begin
                    col        <= '0;
                    phase      <= 1'b1;
                    first_byte <= dout_q;
                end else if (href_q) begin
                    phase <= ~phase;
                    if (!phase)
                        first_byte <= dout_q;
                    else if (col != '1)
                        col <= col + 12'd1;
                end
                if (href_fall && row != '1)
                    row <= row + 12'd1;

                // One-stage hold between word assembly and the FIFO write.
                pend      <= pix_formed && keep;
                pend_word <= word;
                if (pend) begin
                    if (fifo_full) begin
                        overflow <= 1'b1;
                    end else begin
                        w_en   <= 1'b1;
                        w_data <= pend_word;
                        if (run_count != '1)
                            run_count <= run_count + 17'd1;
                    end
                end
            end else begin
                pend <= 1'b0;
            end
        end
    end

endmodule
